// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and memory stages; m wins ties unless
// MEM_PORT_ARB_RR_EN is defined, which alternates ties by most recent grant.
module mem_port_arbiter #(
   parameter int ADDR_W   = 64,
   parameter int DATA_W   = 64,
   parameter int MEM_SIZE = 8192
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_valid,
   output logic [DATA_W-1:0] f_rdata,
   output logic              f_err,
   output logic              f_stall,
   input  logic              m_req,
   input  logic              m_we,
   input  logic [ADDR_W-1:0] m_addr,
   input  logic [DATA_W-1:0] m_wdata,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_rdata,
   output logic              m_err,
   output logic              m_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_err
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] BUSY_F = 3'd1;
   localparam logic [2:0] BUSY_M = 3'd2;
   localparam logic [2:0] ERR_F  = 3'd3;
   localparam logic [2:0] ERR_M  = 3'd4;

   localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_SIZE);

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [DATA_W-1:0] wdata_q;
   logic              m_pref;
   logic              grant_m;
   logic              grant_f;
   logic              idle;

   assign idle    = (state == IDLE);
   assign grant_m = m_req && (m_pref || !f_req);
   assign grant_f = f_req && !grant_m;

`ifdef MEM_PORT_ARB_RR_EN
   // Owner of the most recent grant; cleared so m is preferred after reset.
   logic last_m;

   always_ff @(posedge clk) begin
      if (reset)
         last_m <= 1'b0;
      else if (idle && (grant_m || grant_f))
         last_m <= grant_m;
   end

   assign m_pref = !last_m;
`else
   assign m_pref = 1'b1;
`endif

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (grant_m)
               state_nxt = (m_addr >= LIMIT) ? ERR_M : BUSY_M;
            else if (grant_f)
               state_nxt = (f_addr >= LIMIT) ? ERR_F : BUSY_F;
         end
         BUSY_F, BUSY_M: begin
            if (mem_ack)
               state_nxt = IDLE;
         end
         ERR_F, ERR_M: state_nxt = IDLE;
         default:      state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         state <= state_nxt;
         if (idle && grant_m) begin
            addr_q  <= m_addr;
            we_q    <= m_we;
            wdata_q <= m_wdata;
         end else if (idle && grant_f) begin
            addr_q  <= f_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
         end
      end
   end

   // Every output is forced low while reset is high, even mid-transaction.
   logic busy_f, busy_m, err_f, err_m, done_f, done_m;

   assign busy_f = !reset && (state == BUSY_F);
   assign busy_m = !reset && (state == BUSY_M);
   assign err_f  = !reset && (state == ERR_F);
   assign err_m  = !reset && (state == ERR_M);
   assign done_f = busy_f && mem_ack;
   assign done_m = busy_m && mem_ack;

   assign f_valid = done_f || err_f;
   assign f_err   = (done_f && mem_err) || err_f;
   assign f_rdata = done_f ? mem_rdata : '0;
   assign f_stall = !reset && f_req && !f_valid;

   assign m_valid = done_m || err_m;
   assign m_err   = (done_m && mem_err) || err_m;
   assign m_rdata = (done_m && !we_q) ? mem_rdata : '0;
   assign m_stall = !reset && m_req && !m_valid;

   assign mem_req   = busy_f || busy_m;
   assign mem_we    = busy_m && we_q;
   assign mem_addr  = mem_req ? addr_q : '0;
   assign mem_wdata = busy_m ? wdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference
// model compared every cycle on the falling edge.
module tb_mem_port_arbiter;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam int MS = 8192;

   logic          clk = 1'b0;
   logic          reset;
   logic          f_req;
   logic [AW-1:0] f_addr;
   logic          f_valid;
   logic [DW-1:0] f_rdata;
   logic          f_err;
   logic          f_stall;
   logic          m_req;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          m_valid;
   logic [DW-1:0] m_rdata;
   logic          m_err;
   logic          m_stall;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;
   logic          mem_err;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_SIZE(MS)) dut (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr),
      .f_valid(f_valid), .f_rdata(f_rdata),
      .f_err(f_err), .f_stall(f_stall),
      .m_req(m_req), .m_we(m_we),
      .m_addr(m_addr), .m_wdata(m_wdata),
      .m_valid(m_valid), .m_rdata(m_rdata),
      .m_err(m_err), .m_stall(m_stall),
      .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a transaction is either absent, in flight on the
   // memory port, or an immediate error response; owner tells who gets it.
   int          md_ph = 0;     // 0 none, 1 on memory port, 2 error reply
   bit          md_m = 0;      // 1: owner is memory stage
   logic [63:0] md_addr = '0;
   logic [63:0] md_wdata = '0;
   bit          md_we = 0;
   bit          md_last_m = 0;

   always @(negedge clk) begin
      logic [63:0] e_frd, e_mrd, e_addr, e_wd;
      bit e_fv, e_fe, e_fs, e_mv, e_me, e_ms, e_req, e_we;
      bit fin, pref_m, take_m, take_f;
      e_frd = '0; e_mrd = '0; e_addr = '0; e_wd = '0;
      e_fv = 0; e_fe = 0; e_fs = 0; e_mv = 0;
      e_me = 0; e_ms = 0; e_req = 0; e_we = 0;
      if (!reset) begin
         fin = (md_ph == 1 && mem_ack) || md_ph == 2;
         if (md_ph == 1) begin
            e_req  = 1;
            e_addr = md_addr;
            e_we   = md_m && md_we;
            e_wd   = md_m ? md_wdata : '0;
         end
         if (fin && !md_m) begin
            e_fv  = 1;
            e_fe  = (md_ph == 2) || mem_err;
            e_frd = (md_ph == 1) ? mem_rdata : '0;
         end
         if (fin && md_m) begin
            e_mv  = 1;
            e_me  = (md_ph == 2) || mem_err;
            e_mrd = (md_ph == 1 && !md_we) ? mem_rdata : '0;
         end
         e_fs = f_req && !e_fv;
         e_ms = m_req && !e_mv;
      end
      chk("f_valid", f_valid, e_fv);
      chk("f_err", f_err, e_fe);
      chk("f_rdata", f_rdata, e_frd);
      chk("f_stall", f_stall, e_fs);
      chk("m_valid", m_valid, e_mv);
      chk("m_err", m_err, e_me);
      chk("m_rdata", m_rdata, e_mrd);
      chk("m_stall", m_stall, e_ms);
      chk("mem_req", mem_req, e_req);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wd);
      // advance the model to the state after the coming rising edge
      if (reset) begin
         md_ph = 0; md_m = 0; md_we = 0; md_last_m = 0;
         md_addr = '0; md_wdata = '0;
      end else if (md_ph == 0) begin
`ifdef MEM_PORT_ARB_RR_EN
         pref_m = !md_last_m;
`else
         pref_m = 1;
`endif
         take_m = m_req && (pref_m || !f_req);
         take_f = f_req && !take_m;
         if (take_m) begin
            md_m = 1; md_last_m = 1;
            md_addr = m_addr; md_we = m_we; md_wdata = m_wdata;
            md_ph = (m_addr >= 64'(MS)) ? 2 : 1;
         end else if (take_f) begin
            md_m = 0; md_last_m = 0;
            md_addr = f_addr; md_we = 0; md_wdata = '0;
            md_ph = (f_addr >= 64'(MS)) ? 2 : 1;
         end
      end else if (md_ph == 2 || mem_ack) begin
         md_ph = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      f_req = 0; m_req = 0; m_we = 0;
      mem_ack = 0; mem_err = 0; mem_rdata = '0;
   endtask

   initial begin
      reset = 1; f_req = 1; f_addr = 64'h10;
      m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0;
      mem_ack = 0; mem_rdata = '0; mem_err = 0;
      @(negedge clk);
      chk("rst_f_stall", f_stall, 0);
      chk("rst_mem_req", mem_req, 0);
      tick();
      quiet(); reset = 0;
      @(negedge clk);
      chk("post_rst_req", mem_req, 0);
      tick();

      // fetch read, ack on second memory-port cycle
      f_req = 1; f_addr = 64'h100;
      @(negedge clk);
      chk("s1_idle_stall", f_stall, 1);
      tick();
      f_addr = 64'h200;
      @(negedge clk);
      chk("s1_addr_held", mem_addr, 64'h100);
      chk("s1_wait_valid", f_valid, 0);
      tick();
      mem_ack = 1; mem_rdata = 64'hA5;
      @(negedge clk);
      chk("s1_req2", mem_req, 1);
      chk("s1_rdata", f_rdata, 64'hA5);
      chk("s1_stall_end", f_stall, 0);
      tick();
      quiet();
      @(negedge clk);
      chk("s1_idle", mem_req, 0);
      tick();

      // out-of-range memory-stage address
      m_req = 1; m_addr = 64'(MS);
      @(negedge clk);
      tick();
      @(negedge clk);
      chk("s3_m_err", m_err, 1);
      chk("s3_no_mem", mem_req, 0);
      tick();
      quiet();
      @(negedge clk);
      tick();

      // simultaneous requests; previous grant went to m
      f_req = 1; f_addr = 64'h40;
      m_req = 1; m_we = 1; m_addr = 64'h20; m_wdata = 64'h10;
      @(negedge clk);
      tick();
      mem_ack = 1; mem_rdata = 64'h99;
      @(negedge clk);
`ifdef MEM_PORT_ARB_RR_EN
      chk("s2_first_we", mem_we, 0);
      chk("s2_first_f", f_rdata, 64'h99);
`else
      chk("s2_first_we", mem_we, 1);
      chk("s2_first_wd", mem_wdata, 64'h10);
      chk("s2_wr_rdata", m_rdata, 0);
`endif
      tick();
`ifdef MEM_PORT_ARB_RR_EN
      f_req = 0;
`else
      m_req = 0;
`endif
      mem_ack = 0;
      @(negedge clk);
      chk("s2_gap", mem_req, 0);
      tick();
      mem_ack = 1; mem_rdata = 64'h77;
      @(negedge clk);
`ifdef MEM_PORT_ARB_RR_EN
      chk("s2_second_m", m_valid, 1);
`else
      chk("s2_second_f", f_rdata, 64'h77);
      chk("s2_second_we", mem_we, 0);
`endif
      tick();
      quiet();
      @(negedge clk);
      tick();

      // memory fault on a fetch
      f_req = 1; f_addr = 64'h8;
      @(negedge clk);
      tick();
      mem_ack = 1; mem_err = 1; mem_rdata = 64'h33;
      @(negedge clk);
      chk("s4_f_err", f_err, 1);
      chk("s4_f_valid", f_valid, 1);
      tick();
      quiet();
      @(negedge clk);
      chk("s4_idle", f_valid, 0);
      tick();

      // reset in the middle of a memory-stage read
      m_req = 1; m_we = 0; m_addr = 64'h30;
      @(negedge clk);
      tick();
      @(negedge clk);
      chk("s5_busy", mem_req, 1);
      tick();
      reset = 1; mem_ack = 1; mem_rdata = 64'hEE;
      @(negedge clk);
      chk("s5_rst_valid", m_valid, 0);
      tick();
      quiet(); reset = 0;
      f_req = 1; f_addr = 64'h50;
      @(negedge clk);
      chk("s5_after_rst", mem_req, 0);
      tick();
      mem_ack = 1; mem_rdata = 64'h5A;
      @(negedge clk);
      chk("s5_f_served", f_rdata, 64'h5A);
      tick();
      quiet();
      @(negedge clk);
      tick();

      // stray acknowledge while idle
      mem_ack = 1; mem_rdata = 64'hFF;
      @(negedge clk);
      chk("s6_no_fv", f_valid, 0);
      chk("s6_no_mv", m_valid, 0);
      tick();
      mem_ack = 0;
      @(negedge clk);
      chk("s6_still_idle", mem_req, 0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
